lms_error_unit: RTL and testbench



---
 rtl/lms_error_unit.sv | 189 ++++++++++++++++++
 tb/tb_lms_error_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lms_error_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lms_error_unit
//  Purpose  : Complex LMS error stage for NCH channels. Computes e = d - y,
//             delays it DELAY cycles to line up with the weight-update path,
//             and outputs the conjugate e*. It also measures the error power
//             over a window of WINDOW valid outputs and flags convergence
//             against a runtime threshold.
//  Ports    : clk, rst_n (sync, active-low)
//             in_valid, d_i/d_q, y_i/y_q   - packed NCH*W signed samples
//             thr                          - unsigned convergence threshold
//             out_valid, econj_i/econj_q   - delayed conjugated error
//             err_pow, pow_valid, converged - window power result
//  Options  : LMS_ERR_SAT_EN - saturate the difference and the conjugate
//             instead of wrapping them.
//  Revision : 1.0 - initial release
// ============================================================================
module lms_error_unit #(
  parameter int W      = 18,
  parameter int NCH    = 1,
  parameter int DELAY  = 1,
  parameter int WINDOW = 64,
  parameter int ACC_W  = 2*W + $clog2(NCH) + $clog2(WINDOW) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] d_i,
  input  logic [NCH*W-1:0] d_q,
  input  logic [NCH*W-1:0] y_i,
  input  logic [NCH*W-1:0] y_q,
  input  logic [ACC_W-1:0] thr,
  output logic             out_valid,
  output logic [NCH*W-1:0] econj_i,
  output logic [NCH*W-1:0] econj_q,
  output logic [ACC_W-1:0] err_pow,
  output logic             pow_valid,
  output logic             converged
);

  localparam int              CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [W-1:0]    S_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    S_MIN    = {1'b1, {(W-1){1'b0}}};

  // Reduce a W+1-bit difference to W bits.
  function automatic logic [W-1:0] reduce_diff(input logic [W:0] x);
`ifdef LMS_ERR_SAT_EN
    if (x[W] != x[W-1]) reduce_diff = x[W] ? S_MIN : S_MAX;
    else                reduce_diff = x[W-1:0];
`else
    reduce_diff = x[W-1:0];
`endif
  endfunction

  // Two's-complement negation; the most negative code needs special care.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
`ifdef LMS_ERR_SAT_EN
    if (x == S_MIN) neg_w = S_MAX;
    else            neg_w = -x;
`else
    neg_w = -x;
`endif
  endfunction

  // Square of a signed W-bit value, zero-extended to the accumulator width.
  // The true square is at most 2^(2W-2), so 2W product bits are exact.
  function automatic logic [ACC_W-1:0] sq_w(input logic [W-1:0] x);
    logic signed [2*W-1:0] xe;
    logic        [2*W-1:0] prod;
    xe   = {{W{x[W-1]}}, x};
    prod = xe * xe;
    sq_w = {{(ACC_W-2*W){1'b0}}, prod};
  endfunction

  // -------------------------------------------------------------------------
  // Error computation
  // -------------------------------------------------------------------------
  logic [NCH*W-1:0] e_i, e_q;

  always_comb begin
    e_i = '0;
    e_q = '0;
    for (int k = 0; k < NCH; k++) begin
      e_i[k*W +: W] = reduce_diff({d_i[k*W+W-1], d_i[k*W +: W]}
                                - {y_i[k*W+W-1], y_i[k*W +: W]});
      e_q[k*W +: W] = reduce_diff({d_q[k*W+W-1], d_q[k*W +: W]}
                                - {y_q[k*W+W-1], y_q[k*W +: W]});
    end
  end

  // -------------------------------------------------------------------------
  // Delay line: free-running, bubbles carry zero data so idle outputs read 0
  // -------------------------------------------------------------------------
  logic [DELAY-1:0] vld_q, vld_d;
  logic [NCH*W-1:0] ei_q [DELAY];
  logic [NCH*W-1:0] ei_d [DELAY];
  logic [NCH*W-1:0] eq_q [DELAY];
  logic [NCH*W-1:0] eq_d [DELAY];

  always_comb begin
    vld_d[0] = in_valid;
    ei_d[0]  = in_valid ? e_i : '0;
    eq_d[0]  = in_valid ? e_q : '0;
    for (int s = 1; s < DELAY; s++) begin
      vld_d[s] = vld_q[s-1];
      ei_d[s]  = ei_q[s-1];
      eq_d[s]  = eq_q[s-1];
    end
  end

  logic [NCH*W-1:0] ei_del, eq_del;
  assign ei_del    = ei_q[DELAY-1];
  assign eq_del    = eq_q[DELAY-1];
  assign out_valid = vld_q[DELAY-1];

  always_comb begin
    econj_i = ei_del;
    econj_q = '0;
    for (int k = 0; k < NCH; k++) begin
      econj_q[k*W +: W] = neg_w(eq_del[k*W +: W]);
    end
  end

  // -------------------------------------------------------------------------
  // Window power accumulation (uses the error before conjugation)
  // -------------------------------------------------------------------------
  logic [ACC_W-1:0] p, acc_sum;
  logic [ACC_W-1:0] acc_q, acc_d, err_pow_q, err_pow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pow_valid_q, pow_valid_d, converged_q, converged_d;

  always_comb begin
    p = '0;
    for (int k = 0; k < NCH; k++) begin
      p = p + sq_w(ei_del[k*W +: W]) + sq_w(eq_del[k*W +: W]);
    end
    acc_sum     = acc_q + p;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_pow_d   = err_pow_q;
    converged_d = converged_q;
    pow_valid_d = 1'b0;
    if (out_valid) begin
      if (cnt_q == LAST_CNT) begin
        err_pow_d   = acc_sum;
        converged_d = (acc_sum < thr);
        pow_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < DELAY; s++) begin
        ei_q[s] <= '0;
        eq_q[s] <= '0;
      end
      acc_q       <= '0;
      cnt_q       <= '0;
      err_pow_q   <= '0;
      pow_valid_q <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < DELAY; s++) begin
        ei_q[s] <= ei_d[s];
        eq_q[s] <= eq_d[s];
      end
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_pow_q   <= err_pow_d;
      pow_valid_q <= pow_valid_d;
      converged_q <= converged_d;
    end
  end

  assign err_pow   = err_pow_q;
  assign pow_valid = pow_valid_q;
  assign converged = converged_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_error_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lms_error_unit
//  Purpose  : Directed self-checking bench for lms_error_unit. Three DUT
//             instances: DELAY=1 single channel, DELAY=4 single channel,
//             and NCH=2/WINDOW=4 for the power and convergence logic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lms_error_unit;
  localparam int W  = 18;
  localparam int A1 = 2*W + $clog2(1) + $clog2(64) + 2;
  localparam int AP = 2*W + $clog2(2) + $clog2(4) + 2;

`ifdef LMS_ERR_SAT_EN
  localparam logic [W-1:0] SAT_EXP_I = 18'h1FFFF;  // 131071
  localparam logic [W-1:0] SAT_EXP_Q = 18'h1FFFF;  // 131071
`else
  localparam logic [W-1:0] SAT_EXP_I = 18'h3FFFF;  // -1
  localparam logic [W-1:0] SAT_EXP_Q = 18'h20000;  // -131072
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 1: DELAY=1, NCH=1
  logic          v1;
  logic [W-1:0]  d1i, d1q, y1i, y1q;
  logic [A1-1:0] thr1;
  logic          ov1, pv1, cv1;
  logic [W-1:0]  c1i, c1q;
  logic [A1-1:0] ep1;

  lms_error_unit #(.W(W), .NCH(1), .DELAY(1), .WINDOW(64)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .d_i(d1i), .d_q(d1q), .y_i(y1i), .y_q(y1q), .thr(thr1),
    .out_valid(ov1), .econj_i(c1i), .econj_q(c1q),
    .err_pow(ep1), .pow_valid(pv1), .converged(cv1)
  );

  // Instance 2: DELAY=4, NCH=1
  logic          v4;
  logic [W-1:0]  d4i, d4q, y4i, y4q;
  logic [A1-1:0] thr4;
  logic          ov4, pv4, cv4;
  logic [W-1:0]  c4i, c4q;
  logic [A1-1:0] ep4;

  lms_error_unit #(.W(W), .NCH(1), .DELAY(4), .WINDOW(64)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .d_i(d4i), .d_q(d4q), .y_i(y4i), .y_q(y4q), .thr(thr4),
    .out_valid(ov4), .econj_i(c4i), .econj_q(c4q),
    .err_pow(ep4), .pow_valid(pv4), .converged(cv4)
  );

  // Instance 3: NCH=2, WINDOW=4, DELAY=1
  logic            vp;
  logic [2*W-1:0]  dpi, dpq, ypi, ypq;
  logic [AP-1:0]   thrp;
  logic            ovp, pvp, cvp;
  logic [2*W-1:0]  cpi, cpq;
  logic [AP-1:0]   epp;

  lms_error_unit #(.W(W), .NCH(2), .DELAY(1), .WINDOW(4)) u_pw (
    .clk(clk), .rst_n(rst_n), .in_valid(vp),
    .d_i(dpi), .d_q(dpq), .y_i(ypi), .y_q(ypq), .thr(thrp),
    .out_valid(ovp), .econj_i(cpi), .econj_q(cpq),
    .err_pow(epp), .pow_valid(pvp), .converged(cvp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  task automatic chk_u(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    int pulses;
    logic [7:0] pat;

    rst_n = 1'b0;
    v1 = 1'b0; d1i = '0; d1q = '0; y1i = '0; y1q = '0; thr1 = '0;
    v4 = 1'b0; d4i = '0; d4q = '0; y4i = '0; y4q = '0; thr4 = '0;
    vp = 1'b0; dpi = '0; dpq = '0; ypi = '0; ypq = '0; thrp = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk_u("rst_ov1", 64'(ov1), 64'(0));
    chk_s("rst_c1i", c1i, 18'(0));
    chk_s("rst_c1q", c1q, 18'(0));
    chk_u("rst_ep1", 64'(ep1), 64'(0));
    chk_u("rst_pv1", 64'(pv1), 64'(0));
    chk_u("rst_cv1", 64'(cv1), 64'(0));
    chk_u("rst_ov4", 64'(ov4), 64'(0));
    chk_u("rst_ovp", 64'(ovp), 64'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- basic DELAY=1 ----------------
    v1 = 1'b1; d1i = 18'(1000); d1q = 18'(-500); y1i = 18'(300); y1q = 18'(200);
    tick();
    v1 = 1'b0; d1i = 18'(777); d1q = 18'(555);
    chk_u("d1_ov", 64'(ov1), 64'(1));
    chk_s("d1_ci", c1i, 18'(700));
    chk_s("d1_cq", c1q, 18'(700));
    tick();
    chk_u("d1_ov_idle", 64'(ov1), 64'(0));
    chk_s("d1_ci_idle", c1i, 18'(0));
    chk_s("d1_cq_idle", c1q, 18'(0));

    // ---------------- saturation / wrap ----------------
    v1 = 1'b1; d1i = 18'(131071); y1i = 18'(-131072); d1q = 18'(-131072); y1q = 18'(0);
    tick();
    v1 = 1'b0;
    chk_u("sat_ov", 64'(ov1), 64'(1));
    chk_s("sat_ci", c1i, SAT_EXP_I);
    chk_s("sat_cq", c1q, SAT_EXP_Q);
    tick();

    // ---------------- DELAY=4 with bubble ----------------
    v4 = 1'b1; d4i = 18'(11); d4q = 18'(5); y4i = 18'(0); y4q = 18'(0);
    tick();
    v4 = 1'b0; d4i = 18'(999); d4q = 18'(999);
    tick();
    v4 = 1'b1; d4i = 18'(33); d4q = 18'(7);
    tick();
    chk_u("d4_ov_early", 64'(ov4), 64'(0));
    v4 = 1'b1; d4i = 18'(44); d4q = 18'(8);
    tick();
    v4 = 1'b0; d4i = 18'(0); d4q = 18'(0);
    chk_u("d4_ov0", 64'(ov4), 64'(1));
    chk_s("d4_ci0", c4i, 18'(11));
    chk_s("d4_cq0", c4q, 18'(-5));
    tick();
    chk_u("d4_ov1", 64'(ov4), 64'(0));
    chk_s("d4_ci1", c4i, 18'(0));
    tick();
    chk_u("d4_ov2", 64'(ov4), 64'(1));
    chk_s("d4_ci2", c4i, 18'(33));
    chk_s("d4_cq2", c4q, 18'(-7));
    tick();
    chk_u("d4_ov3", 64'(ov4), 64'(1));
    chk_s("d4_ci3", c4i, 18'(44));
    chk_s("d4_cq3", c4q, 18'(-8));
    tick();
    chk_u("d4_ov4", 64'(ov4), 64'(0));

    // ---------------- power window, converged ----------------
    dpi = {18'(10), 18'(10)}; dpq = {18'(10), 18'(10)};
    ypi = '0; ypq = '0;
    thrp = AP'(2000);
    vp = 1'b1;
    tick();
    chk_u("pw_ov", 64'(ovp), 64'(1));
    chk_s("pw_ci_ch1", cpi[2*W-1:W], 18'(10));
    chk_s("pw_cq_ch0", cpq[W-1:0], 18'(-10));
    tick(); tick(); tick();
    vp = 1'b0;
    chk_u("pw_pv_early", 64'(pvp), 64'(0));
    tick();
    chk_u("pw_pv", 64'(pvp), 64'(1));
    chk_u("pw_pow", 64'(epp), 64'(1600));
    chk_u("pw_conv", 64'(cvp), 64'(1));
    tick();
    chk_u("pw_pv_drop", 64'(pvp), 64'(0));
    chk_u("pw_pow_hold", 64'(epp), 64'(1600));

    // ---------------- gaps, threshold equal -> not converged ----------------
    thrp = AP'(1600);
    pat = 8'b0110_1001;  // bit i drives cycle i: 1,0,0,1,0,1,1,0
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      vp = pat[i];
      tick();
      if (i < 7) pulses += int'(pvp);
    end
    vp = 1'b0;
    chk_u("gap_no_early_pulse", 64'(pulses), 64'(0));
    chk_u("gap_pv", 64'(pvp), 64'(1));
    chk_u("gap_pow", 64'(epp), 64'(1600));
    chk_u("gap_conv", 64'(cvp), 64'(0));
    tick();
    chk_u("gap_pv_drop", 64'(pvp), 64'(0));

    // ---------------- reset mid-window ----------------
    thrp = AP'(2000);
    vp = 1'b1;
    tick(); tick();
    vp = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk_u("mrst_ov", 64'(ovp), 64'(0));
    chk_u("mrst_pow", 64'(epp), 64'(0));
    chk_u("mrst_pv", 64'(pvp), 64'(0));
    chk_u("mrst_conv", 64'(cvp), 64'(0));
    chk_u("mrst_ci", 64'(cpi), 64'(0));
    rst_n = 1'b1;
    vp = 1'b1;
    tick(); tick(); tick(); tick();
    vp = 1'b0;
    tick();
    chk_u("mrst_pv_after", 64'(pvp), 64'(1));
    chk_u("mrst_pow_after", 64'(epp), 64'(1600));
    chk_u("mrst_conv_after", 64'(cvp), 64'(1));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
